// File: rtl/recuantizador_sat_pkg.sv
// Shared constants for the requantiser: rounding-mode encodings.
package recuantizador_sat_pkg;
    localparam logic [1:0] MODE_TRUNC = 2'b00;
    localparam logic [1:0] MODE_RHU   = 2'b01;
    localparam logic [1:0] MODE_CONV  = 2'b10;
endpackage

// File: rtl/recuantizador_sat_if.sv
// Sample stream in/out of the requantiser with valid/ready on both sides.
interface recuantizador_sat_if #(
    parameter int N_IN  = 16,
    parameter int N_OUT = 8
);
    logic [N_IN-1:0]  in_data;
    logic [1:0]       in_mode;
    logic             in_valid;
    logic             in_ready;
    logic [N_OUT-1:0] out_data;
    logic             out_sat;
    logic             out_valid;
    logic             out_ready;

    modport master (output in_data, in_mode, in_valid, out_ready,
                    input  in_ready, out_data, out_sat, out_valid);
    modport slave  (input  in_data, in_mode, in_valid, out_ready,
                    output in_ready, out_data, out_sat, out_valid);
endinterface

// File: rtl/recuantizador_sat_saturador.sv
// Combinational shift-and-clamp of the rounded sum down to N_OUT bits,
// with optional MSB inversion for offset-binary DACs.
module saturador #(
    parameter int N_IN       = 16,
    parameter int N_OUT      = 8,
    parameter int SHIFT      = N_IN - N_OUT,
    parameter int OFFSET_BIN = 0
) (
    input  logic signed [N_IN:0] sum,
    output logic [N_OUT-1:0]     word,
    output logic                 sat
);
    localparam logic signed [N_IN:0] QMAX = {{(N_IN-N_OUT+2){1'b0}}, {(N_OUT-1){1'b1}}};
    localparam logic signed [N_IN:0] QMIN = {{(N_IN-N_OUT+2){1'b1}}, {(N_OUT-1){1'b0}}};

    logic signed [N_IN:0] q;
    assign q = sum >>> SHIFT;

    always_comb begin
        sat  = 1'b0;
        word = q[N_OUT-1:0];
        if (q > QMAX) begin
            sat  = 1'b1;
            word = {1'b0, {(N_OUT-1){1'b1}}};
        end else if (q < QMIN) begin
            sat  = 1'b1;
            word = {1'b1, {(N_OUT-1){1'b0}}};
        end
        if (OFFSET_BIN != 0) word[N_OUT-1] = ~word[N_OUT-1];
    end
endmodule

// File: rtl/recuantizador_sat.sv
// Two-stage requantiser: rounding offset add, then shift/saturate, with
// valid/ready back-pressure and saturation statistics.
module recuantizador_sat
    import recuantizador_sat_pkg::*;
#(
    parameter int N_IN       = 16,
    parameter int N_OUT      = 8,
    parameter int SHIFT      = N_IN - N_OUT,
    parameter int OFFSET_BIN = 0,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    recuantizador_sat_if.slave bus,
    input  logic             sat_clr,
    output logic             sat_sticky,
    output logic [CNT_W-1:0] sat_count
);
    localparam int W   = N_IN + 1;
    localparam int SH1 = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [W-1:0] HALF = W'(1) << SH1;

    logic                en;
    logic [1:0]          vld_pipe;
    logic [W-1:0]        offset;
    logic signed [W-1:0] s1_sum;
    logic [N_OUT-1:0]    sat_word, out_data_q;
    logic                sat_flag, out_sat_q;

    // Stall the whole pipe only when the output register is full and blocked.
    assign en            = !vld_pipe[1] || bus.out_ready;
    assign bus.in_ready  = en;
    assign bus.out_valid = vld_pipe[1];
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;

    always_comb begin
        offset = '0;
        if (SHIFT != 0) begin
            case (bus.in_mode)
                MODE_RHU:  offset = HALF;
                MODE_CONV: offset = HALF - W'(1) + W'(bus.in_data[SHIFT]);
                default:   offset = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_pipe <= '0;
            s1_sum   <= '0;
        end else if (en) begin
            vld_pipe <= {vld_pipe[0], bus.in_valid};
            // One guard bit keeps the rounded sum from wrapping near +full-scale.
            if (bus.in_valid) s1_sum <= {bus.in_data[N_IN-1], bus.in_data} + offset;
        end
    end

    saturador #(
        .N_IN(N_IN), .N_OUT(N_OUT), .SHIFT(SHIFT), .OFFSET_BIN(OFFSET_BIN)
    ) u_sat (
        .sum(s1_sum), .word(sat_word), .sat(sat_flag)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else if (en && vld_pipe[0]) begin
            out_data_q <= sat_word;
            out_sat_q  <= sat_flag;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_sticky <= 1'b0;
            sat_count  <= '0;
        end else if (sat_clr) begin
            sat_sticky <= 1'b0;
            sat_count  <= '0;
        end else if (vld_pipe[1] && bus.out_ready && out_sat_q) begin
            sat_sticky <= 1'b1;
            if (sat_count != '1) sat_count <= sat_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_recuantizador_sat.sv
// Bench: three DUT variants share one stimulus stream and are scored against a
// plain-arithmetic model of the requantisation rules.
module tb_recuantizador_sat;
    import recuantizador_sat_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] in_data = '0;
    logic [1:0]  in_mode = '0;
    logic        in_valid = 1'b0, out_ready = 1'b1, sat_clr = 1'b0;
    logic        st0, st1, st2;
    logic [15:0] c0, c1;
    logic [3:0]  c2;
    int total = 0, bad = 0;

    recuantizador_sat_if #(.N_IN(16), .N_OUT(8)) b0 ();
    recuantizador_sat_if #(.N_IN(16), .N_OUT(8)) b1 ();
    recuantizador_sat_if #(.N_IN(16), .N_OUT(8)) b2 ();

    assign b0.in_data = in_data;  assign b1.in_data = in_data;  assign b2.in_data = in_data;
    assign b0.in_mode = in_mode;  assign b1.in_mode = in_mode;  assign b2.in_mode = in_mode;
    assign b0.in_valid = in_valid; assign b1.in_valid = in_valid; assign b2.in_valid = in_valid;
    assign b0.out_ready = out_ready; assign b1.out_ready = out_ready; assign b2.out_ready = out_ready;

    recuantizador_sat #(.N_IN(16), .N_OUT(8), .SHIFT(8), .OFFSET_BIN(0), .CNT_W(16)) dut0 (
        .clk(clk), .reset(reset), .bus(b0.slave), .sat_clr(sat_clr), .sat_sticky(st0), .sat_count(c0));
    recuantizador_sat #(.N_IN(16), .N_OUT(8), .SHIFT(8), .OFFSET_BIN(1), .CNT_W(16)) dut1 (
        .clk(clk), .reset(reset), .bus(b1.slave), .sat_clr(sat_clr), .sat_sticky(st1), .sat_count(c1));
    recuantizador_sat #(.N_IN(16), .N_OUT(8), .SHIFT(8), .OFFSET_BIN(0), .CNT_W(4)) dut2 (
        .clk(clk), .reset(reset), .bus(b2.slave), .sat_clr(sat_clr), .sat_sticky(st2), .sat_count(c2));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: add rounding offset, floor-divide by 2^8, clamp to [-128,127].
    function automatic logic [8:0] model(input logic [15:0] d, input logic [1:0] m, input bit ob);
        int x, off, sum, q;
        logic [7:0] w;
        logic s;
        x = int'($signed(d));
        off = 0;
        if (m == MODE_RHU) off = 128;
        else if (m == MODE_CONV) off = 127 + int'(d[8]);
        sum = x + off;
        q = (sum >= 0) ? sum / 256 : -((-sum + 255) / 256);
        s = 1'b0;
        if (q > 127) begin q = 127; s = 1'b1; end
        else if (q < -128) begin q = -128; s = 1'b1; end
        w = 8'(q);
        if (ob) w = w ^ 8'h80;
        return {s, w};
    endfunction

    typedef struct { logic [15:0] d; logic [1:0] m; } smp_t;
    smp_t sq[$];
    smp_t s;
    int cnt0 = 0, cnt2 = 0;
    bit stk = 0, held = 0, ev;
    logic [8:0] held_w, e0, e1;

    always @(negedge clk) begin
        if (reset) begin
            sq.delete(); cnt0 = 0; cnt2 = 0; stk = 0; held = 0;
        end else begin
            chk("in_ready", b0.in_ready, !b0.out_valid || out_ready);
            chk("valid_agree", {b1.out_valid, b2.out_valid}, {2{b0.out_valid}});
            if (held) begin
                chk("hold_valid", b0.out_valid, 1);
                chk("hold_word", {b0.out_sat, b0.out_data}, held_w);
            end
            held = b0.out_valid && !out_ready;
            held_w = {b0.out_sat, b0.out_data};
            chk("count16", c0, cnt0);
            chk("count4", c2, cnt2);
            chk("sticky", {st0, st1, st2}, {3{stk}});
            ev = 0;
            if (b0.out_valid && out_ready) begin
                chk("out_has_input", sq.size() != 0, 1);
                if (sq.size() != 0) begin
                    s = sq.pop_front();
                    e0 = model(s.d, s.m, 0);
                    e1 = model(s.d, s.m, 1);
                    chk("out_tc", {b0.out_sat, b0.out_data}, e0);
                    chk("out_ob", {b1.out_sat, b1.out_data}, e1);
                    chk("out_c4", {b2.out_sat, b2.out_data}, e0);
                    ev = e0[8];
                end
            end
            if (sat_clr) begin cnt0 = 0; cnt2 = 0; stk = 0; end
            else if (ev) begin
                stk = 1;
                if (cnt0 < 65535) cnt0++;
                if (cnt2 < 15) cnt2++;
            end
            if (in_valid && b0.in_ready) sq.push_back('{in_data, in_mode});
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send_accept(input logic [15:0] d, input logic [1:0] m);
        int n;
        in_data = d; in_mode = m; in_valid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!b0.in_ready && n < 20);
        if (n >= 20) chk("accept_timeout", n, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic one(input logic [15:0] d, input logic [1:0] m,
                       input logic [7:0] x0, input logic xs, input logic [7:0] x1);
        int n;
        send_accept(d, m);
        n = 0;
        while (!b0.out_valid && n < 10) begin @(negedge clk); n++; end
        chk("latency", n, 2);
        chk("lit_tc", b0.out_data, x0);
        chk("lit_sat", b0.out_sat, xs);
        chk("lit_ob", b1.out_data, x1);
        @(posedge clk); #1;
    endtask

    int drops;
    logic [15:0] tmp;

    initial begin
        #12;
        chk("rst_valid", b0.out_valid, 0);
        chk("rst_data", b0.out_data, 0);
        chk("rst_sat", b0.out_sat, 0);
        chk("rst_count", c0, 0);
        chk("rst_sticky", st0, 0);
        chk("rst_in_ready", b0.in_ready, 1);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;

        one(16'h1280, MODE_TRUNC, 8'h12, 0, 8'h92);
        one(16'h1280, MODE_RHU,   8'h13, 0, 8'h93);
        one(16'h1280, MODE_CONV,  8'h12, 0, 8'h92);
        one(16'h1380, MODE_CONV,  8'h14, 0, 8'h94);
        one(16'h12FF, 2'b11,      8'h12, 0, 8'h92);
        one(16'h7FF0, MODE_RHU,   8'h7F, 1, 8'hFF);
        chk("ovf_count", c0, 1);
        chk("ovf_sticky", st0, 1);
        one(16'h8000, MODE_TRUNC, 8'h80, 0, 8'h00);
        one(16'h0000, MODE_TRUNC, 8'h00, 0, 8'h80);
        one(16'h7FFF, MODE_TRUNC, 8'h7F, 0, 8'hFF);

        // Back-pressure: 5 samples with a 3-cycle stall in the middle.
        drops = 0;
        fork
            for (int i = 0; i < 5; i++) send_accept(16'h0100 * 16'(i) + 16'h0040, 2'(i % 3));
            begin repeat (2) @(posedge clk); #1 out_ready = 1'b0; repeat (3) @(posedge clk); #1 out_ready = 1'b1; end
            repeat (12) begin @(negedge clk); if (!b0.in_ready) drops++; end
        join
        chk("bp_in_ready_drop", drops > 0, 1);
        @(posedge clk); #1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("bp_drained", sq.size(), 0);
        @(posedge clk); #1;

        // Counter saturation at 4 bits.
        sat_clr = 1'b1; @(posedge clk); #1 sat_clr = 1'b0;
        for (int i = 0; i < 20; i++) send_accept(16'h7FF0, MODE_RHU);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("cnt4_hold", c2, 4'hF);
        chk("cnt16_20", c0, 20);
        chk("cnt_sticky", st0, 1);
        @(posedge clk); #1;

        // Clear in the very cycle a saturated word transfers.
        send_accept(16'h7FF0, MODE_RHU);
        @(posedge clk); #1;
        chk("clr_cycle_valid", b0.out_valid, 1);
        sat_clr = 1'b1;
        @(posedge clk); #1 sat_clr = 1'b0;
        @(negedge clk);
        chk("clr_prio_count", c0, 0);
        chk("clr_prio_sticky", st0, 0);
        @(posedge clk); #1;

        // Reset with two samples in flight.
        send_accept(16'h2000, MODE_TRUNC);
        send_accept(16'h3000, MODE_TRUNC);
        reset = 1'b1;
        #1 chk("rst_mid_valid", b0.out_valid, 0);
        @(negedge clk);
        @(posedge clk); #1 reset = 1'b0;
        repeat (3) begin @(negedge clk); chk("no_stale", b0.out_valid, 0); end
        @(posedge clk); #1;
        one(16'h0500, MODE_TRUNC, 8'h05, 0, 8'h85);

        // Randomised traffic with random stalls and occasional clears.
        repeat (400) begin
            tmp = 16'($urandom);
            if ($urandom_range(0, 1) == 1) tmp = {{7{tmp[15]}}, tmp[15:7]};
            in_data = tmp;
            in_mode = 2'($urandom_range(0, 3));
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            sat_clr = ($urandom_range(0, 31) == 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("rand_drained", sq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
